// File: rtl/sdram_access_scheduler.sv
// Arbitrates the flight-recorder write path and downlink read path onto the single
// SDRAM command port, tracks store occupancy and pulses the traversal counters' NEXT.
module sdram_access_scheduler #(
  parameter int DEPTH_LOG2     = 24,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        WR_REQ,
  input  logic        RD_REQ,
  input  logic [1:0]  BA_WR_IN,
  input  logic [12:0] ROW_WR_IN,
  input  logic [8:0]  COL_WR_IN,
  input  logic [1:0]  BA_RD_IN,
  input  logic [12:0] ROW_RD_IN,
  input  logic [8:0]  COL_RD_IN,
  input  logic        CMD_READY,
  input  logic        CMD_DONE,
  output logic        CMD_VALID,
  output logic        CMD_WRITE,
  output logic [1:0]  CMD_BA,
  output logic [12:0] CMD_ROW,
  output logic [8:0]  CMD_COL,
  output logic        WR_NEXT,
  output logic        RD_NEXT,
  output logic        WR_ACK,
  output logic        RD_ACK,
  output logic        EMPTY,
  output logic        FULL,
  output logic        OVERFLOW,
  output logic        TIMEOUT_ERR
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ADVANCE} state_t;

  localparam logic [DEPTH_LOG2:0] CAPACITY = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] OCC_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0] OCC_ZERO = '0;
  localparam logic [7:0]          TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t                state;
  state_t                state_nxt;
  logic                  last_wr;
  logic [7:0]            tmo_cnt;
  logic [DEPTH_LOG2:0]   occ;
  logic [DEPTH_LOG2:0]   occ_nxt;
  logic                  wr_elig;
  logic                  rd_elig;
  logic                  grant_wr;
  logic                  grant;
  logic                  tmo_expire;
  logic                  adv_wr;
  logic                  adv_rd;
  logic [1:0]            sel_ba;
  logic [12:0]           sel_row;
  logic [8:0]            sel_col;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_nxt;
  end

  // Round-robin: on contention the requester not served last wins.
  always_comb begin
    wr_elig    = WR_REQ & ~FULL;
    rd_elig    = RD_REQ & ~EMPTY;
    grant_wr   = wr_elig & (~rd_elig | ~last_wr);
    grant      = 1'b0;
    tmo_expire = 1'b0;
    state_nxt  = state;
    case (state)
      IDLE: begin
        if (wr_elig | rd_elig) begin
          grant     = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (CMD_READY) state_nxt = WAIT;
      end
      WAIT: begin
        if (CMD_DONE) begin
          state_nxt = ADVANCE;
        end else if (tmo_cnt == TMO_LAST) begin
          tmo_expire = 1'b1;
          state_nxt  = IDLE;
        end
      end
      ADVANCE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sel_ba  = grant_wr ? BA_WR_IN  : BA_RD_IN;
    sel_row = grant_wr ? ROW_WR_IN : ROW_RD_IN;
    sel_col = grant_wr ? COL_WR_IN : COL_RD_IN;
  end

  // Occupancy moves only when an access completes; guards keep it from wrapping.
  always_comb begin
    adv_wr  = (state == ADVANCE) & CMD_WRITE;
    adv_rd  = (state == ADVANCE) & ~CMD_WRITE;
    occ_nxt = occ;
    if (adv_wr && occ != CAPACITY)      occ_nxt = occ + OCC_ONE;
    else if (adv_rd && occ != OCC_ZERO) occ_nxt = occ - OCC_ONE;
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      CMD_VALID   <= 1'b0;
      CMD_WRITE   <= 1'b0;
      CMD_BA      <= '0;
      CMD_ROW     <= '0;
      CMD_COL     <= '0;
      WR_NEXT     <= 1'b0;
      RD_NEXT     <= 1'b0;
      WR_ACK      <= 1'b0;
      RD_ACK      <= 1'b0;
      last_wr     <= 1'b0;
      tmo_cnt     <= '0;
      occ         <= '0;
      EMPTY       <= 1'b1;
      FULL        <= 1'b0;
      OVERFLOW    <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      CMD_VALID <= (state_nxt == ISSUE);
      if (grant) begin
        CMD_WRITE <= grant_wr;
        CMD_BA    <= sel_ba;
        CMD_ROW   <= sel_row;
        CMD_COL   <= sel_col;
        last_wr   <= grant_wr;
      end
      WR_NEXT <= (state_nxt == ADVANCE) & CMD_WRITE;
      RD_NEXT <= (state_nxt == ADVANCE) & ~CMD_WRITE;
      WR_ACK  <= (state_nxt == ADVANCE) & CMD_WRITE;
      RD_ACK  <= (state_nxt == ADVANCE) & ~CMD_WRITE;
      tmo_cnt <= (state == WAIT) ? tmo_cnt + 8'd1 : 8'd0;
      occ     <= occ_nxt;
      EMPTY   <= (occ_nxt == OCC_ZERO);
      FULL    <= (occ_nxt == CAPACITY);
      if (WR_REQ && FULL) OVERFLOW    <= 1'b1;
      if (tmo_expire)     TIMEOUT_ERR <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sdram_access_scheduler.sv
// Directed bench for sdram_access_scheduler; a small store (DEPTH_LOG2=3) makes FULL reachable.
module tb_sdram_access_scheduler;

  localparam logic [23:0] STRIDE = 24'h40_2011;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        WR_REQ = 1'b0;
  logic        RD_REQ = 1'b0;
  logic        CMD_READY = 1'b0;
  logic        CMD_DONE = 1'b0;
  logic [23:0] wa = 24'hB2_3C5D;
  logic [23:0] ra = 24'h4A_1E63;
  logic [1:0]  BA_WR_IN, BA_RD_IN;
  logic [12:0] ROW_WR_IN, ROW_RD_IN;
  logic [8:0]  COL_WR_IN, COL_RD_IN;
  logic        CMD_VALID, CMD_WRITE;
  logic [1:0]  CMD_BA;
  logic [12:0] CMD_ROW;
  logic [8:0]  CMD_COL;
  logic        WR_NEXT, RD_NEXT, WR_ACK, RD_ACK;
  logic        EMPTY, FULL, OVERFLOW, TIMEOUT_ERR;

  int checks = 0;
  int failures = 0;
  int exp_occ = 0;
  int wr_next_cnt = 0;
  int rd_next_cnt = 0;

  assign BA_WR_IN  = wa[23:22];
  assign ROW_WR_IN = wa[21:9];
  assign COL_WR_IN = wa[8:0];
  assign BA_RD_IN  = ra[23:22];
  assign ROW_RD_IN = ra[21:9];
  assign COL_RD_IN = ra[8:0];

  sdram_access_scheduler #(.DEPTH_LOG2(3), .TIMEOUT_CYCLES(255)) dut (
    .CLK(CLK), .RESET(RESET), .WR_REQ(WR_REQ), .RD_REQ(RD_REQ),
    .BA_WR_IN(BA_WR_IN), .ROW_WR_IN(ROW_WR_IN), .COL_WR_IN(COL_WR_IN),
    .BA_RD_IN(BA_RD_IN), .ROW_RD_IN(ROW_RD_IN), .COL_RD_IN(COL_RD_IN),
    .CMD_READY(CMD_READY), .CMD_DONE(CMD_DONE),
    .CMD_VALID(CMD_VALID), .CMD_WRITE(CMD_WRITE),
    .CMD_BA(CMD_BA), .CMD_ROW(CMD_ROW), .CMD_COL(CMD_COL),
    .WR_NEXT(WR_NEXT), .RD_NEXT(RD_NEXT), .WR_ACK(WR_ACK), .RD_ACK(RD_ACK),
    .EMPTY(EMPTY), .FULL(FULL), .OVERFLOW(OVERFLOW), .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (WR_NEXT === 1'b1) wr_next_cnt <= wr_next_cnt + 1;
    if (RD_NEXT === 1'b1) rd_next_cnt <= rd_next_cnt + 1;
  end

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one access to completion; returns during the ADVANCE cycle.
  task automatic serve(input logic wr, input logic stray, input string tag);
    int n = 0;
    logic [23:0] ea;
    ea = wr ? wa : ra;
    while (CMD_VALID !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_valid"}, 32'(CMD_VALID), 32'd1);
    chk({tag, "_write"}, 32'(CMD_WRITE), 32'(wr));
    chk({tag, "_addr"}, 32'({CMD_BA, CMD_ROW, CMD_COL}), 32'(ea));
    if (stray) begin
      CMD_DONE = 1'b1;
      step();
      CMD_DONE = 1'b0;
      chk({tag, "_stray_hold"}, 32'(CMD_VALID), 32'd1);
      chk({tag, "_stray_ack"}, 32'(WR_ACK | RD_ACK), 32'd0);
    end
    CMD_READY = 1'b1;
    step();
    CMD_READY = 1'b0;
    chk({tag, "_handshake"}, 32'(CMD_VALID), 32'd0);
    CMD_DONE = 1'b1;
    step();
    CMD_DONE = 1'b0;
    if (wr) begin
      chk({tag, "_wr_ack"}, 32'({WR_ACK, WR_NEXT, RD_ACK, RD_NEXT}), 32'b1100);
      wa = wa + STRIDE;
      exp_occ++;
    end else begin
      chk({tag, "_rd_ack"}, 32'({WR_ACK, WR_NEXT, RD_ACK, RD_NEXT}), 32'b0011);
      ra = ra + STRIDE;
      exp_occ--;
    end
  endtask

  initial begin
    int seen;
    int wr_snap;
    int rd_snap;
    logic [23:0] held_addr;

    // Reset values
    step();
    step();
    chk("rst_cmd", 32'({CMD_VALID, CMD_WRITE, CMD_BA, CMD_ROW, CMD_COL}), 32'd0);
    chk("rst_pulses", 32'({WR_NEXT, RD_NEXT, WR_ACK, RD_ACK}), 32'd0);
    chk("rst_flags", 32'({EMPTY, FULL, OVERFLOW, TIMEOUT_ERR}), 32'b1000);
    chk("rst_occ", 32'(dut.occ), 32'd0);
    RESET = 1'b1;
    step();

    // Read against an empty store is never granted
    RD_REQ = 1'b1;
    seen = 0;
    repeat (20) begin
      step();
      if (CMD_VALID === 1'b1) seen++;
    end
    chk("rd_empty_no_grant", 32'(seen), 32'd0);
    chk("rd_empty_flag", 32'(EMPTY), 32'd1);

    // First write with exact cycle timing
    WR_REQ = 1'b1;
    step();
    chk("w1_grant_latency", 32'(CMD_VALID), 32'd1);
    chk("w1_write", 32'(CMD_WRITE), 32'd1);
    chk("w1_addr", 32'({CMD_BA, CMD_ROW, CMD_COL}), 32'(wa));
    CMD_READY = 1'b1;
    step();
    CMD_READY = 1'b0;
    chk("w1_handshake", 32'(CMD_VALID), 32'd0);
    CMD_DONE = 1'b1;
    step();
    CMD_DONE = 1'b0;
    chk("w1_advance", 32'({WR_ACK, WR_NEXT, RD_ACK, RD_NEXT}), 32'b1100);
    WR_REQ = 1'b0;
    wa = wa + STRIDE;
    exp_occ = 1;
    step();
    chk("w1_pulse_end", 32'({WR_ACK, WR_NEXT}), 32'd0);
    chk("w1_empty", 32'(EMPTY), 32'd0);
    chk("w1_occ", 32'(dut.occ), 32'(exp_occ));
    chk("w1_next_cnt", 32'(wr_next_cnt), 32'd1);

    // The pending read now goes through; a stray CMD_DONE in ISSUE is ignored
    serve(1'b0, 1'b1, "r1");
    RD_REQ = 1'b0;
    step();
    chk("r1_occ", 32'(dut.occ), 32'd0);
    chk("r1_empty", 32'(EMPTY), 32'd1);
    chk("r1_next_cnt", 32'(rd_next_cnt), 32'd1);

    // Six writes then one read leaves occupancy 5 with read granted last
    for (int i = 0; i < 6; i++) begin
      WR_REQ = 1'b1;
      serve(1'b1, 1'b0, "fill_a");
      WR_REQ = 1'b0;
      step();
    end
    chk("fill_a_occ", 32'(dut.occ), 32'd6);
    RD_REQ = 1'b1;
    serve(1'b0, 1'b0, "r2");
    RD_REQ = 1'b0;
    step();
    chk("r2_occ", 32'(dut.occ), 32'd5);

    // Both held: W, R, W, R
    WR_REQ = 1'b1;
    RD_REQ = 1'b1;
    serve(1'b1, 1'b0, "alt0");
    serve(1'b0, 1'b0, "alt1");
    serve(1'b1, 1'b0, "alt2");
    serve(1'b0, 1'b0, "alt3");
    WR_REQ = 1'b0;
    RD_REQ = 1'b0;
    step();
    chk("alt_occ", 32'(dut.occ), 32'd5);

    // Fill to capacity, then a write request must be refused and flag OVERFLOW
    for (int i = 0; i < 3; i++) begin
      WR_REQ = 1'b1;
      serve(1'b1, 1'b0, "fill_b");
      WR_REQ = 1'b0;
      step();
    end
    chk("full_flag", 32'(FULL), 32'd1);
    chk("full_occ", 32'(dut.occ), 32'd8);
    chk("full_no_ovf_yet", 32'(OVERFLOW), 32'd0);
    WR_REQ = 1'b1;
    seen = 0;
    repeat (10) begin
      step();
      if (CMD_VALID === 1'b1) seen++;
    end
    chk("full_no_grant", 32'(seen), 32'd0);
    chk("overflow_set", 32'(OVERFLOW), 32'd1);
    WR_REQ = 1'b0;
    repeat (3) step();
    chk("overflow_sticky", 32'(OVERFLOW), 32'd1);
    RD_REQ = 1'b1;
    serve(1'b0, 1'b0, "r_full");
    RD_REQ = 1'b0;
    step();
    chk("unfull_occ", 32'(dut.occ), 32'd7);
    chk("unfull_flag", 32'(FULL), 32'd0);

    // Timeout: CMD_DONE withheld for 255 WAIT cycles
    wr_snap = wr_next_cnt;
    WR_REQ = 1'b1;
    step();
    chk("to_valid", 32'(CMD_VALID), 32'd1);
    held_addr = {CMD_BA, CMD_ROW, CMD_COL};
    chk("to_addr", 32'(held_addr), 32'(wa));
    CMD_READY = 1'b1;
    step();
    CMD_READY = 1'b0;
    repeat (254) step();
    chk("to_not_yet", 32'(TIMEOUT_ERR), 32'd0);
    step();
    chk("to_err", 32'(TIMEOUT_ERR), 32'd1);
    chk("to_no_valid", 32'(CMD_VALID), 32'd0);
    chk("to_no_next", 32'(wr_next_cnt), 32'(wr_snap));
    chk("to_occ", 32'(dut.occ), 32'd7);
    step();
    chk("to_retry_valid", 32'(CMD_VALID), 32'd1);
    chk("to_retry_addr", 32'({CMD_BA, CMD_ROW, CMD_COL}), 32'(held_addr));
    serve(1'b1, 1'b0, "to_retry");
    WR_REQ = 1'b0;
    step();
    chk("to_retry_occ", 32'(dut.occ), 32'd8);
    chk("to_err_sticky", 32'(TIMEOUT_ERR), 32'd1);

    // Reset in the middle of a read access
    rd_snap = rd_next_cnt;
    RD_REQ = 1'b1;
    step();
    chk("mr_valid", 32'(CMD_VALID), 32'd1);
    CMD_READY = 1'b1;
    step();
    CMD_READY = 1'b0;
    step();
    RESET = 1'b0;
    #1;
    chk("mr_cmd", 32'({CMD_VALID, CMD_WRITE, CMD_BA, CMD_ROW, CMD_COL}), 32'd0);
    chk("mr_flags", 32'({EMPTY, FULL, OVERFLOW, TIMEOUT_ERR}), 32'b1000);
    chk("mr_occ", 32'(dut.occ), 32'd0);
    RD_REQ = 1'b0;
    CMD_DONE = 1'b1;
    step();
    CMD_DONE = 1'b0;
    RESET = 1'b1;
    step();
    step();
    chk("mr_no_next", 32'(rd_next_cnt), 32'(rd_snap));
    chk("mr_no_ack", 32'({RD_ACK, WR_ACK, CMD_VALID}), 32'd0);
    exp_occ = 0;
    WR_REQ = 1'b1;
    step();
    chk("mr_idle_grant", 32'(CMD_VALID), 32'd1);
    serve(1'b1, 1'b0, "mr_w");
    WR_REQ = 1'b0;
    step();
    chk("mr_w_occ", 32'(dut.occ), 32'(exp_occ));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
